// File: rtl/spi_xfer_ctrl.sv
// SPI master transfer sequencer: generates SCLK/CS_n and drives the PISO/SIPO
// shift-register controls for multi-word transmit or receive bursts.
module spi_xfer_ctrl #(
  parameter int WordLen = 8,
  parameter int DivW    = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            Start,
  input  logic            Dir,
  input  logic            CPOL,
  input  logic [DivW-1:0] ClkDiv,
  input  logic [7:0]      NumWords,
  input  logic            TxValid,
  output logic            TxReady,
  output logic            RxValid,
  output logic            SCLK,
  output logic            CS_n,
  output logic            EnPISO,
  output logic            LoadPISO,
  output logic            SCLKEdgeFlg,
  output logic            WordFlg,
  output logic            TristateMode,
  output logic            Busy,
  output logic            Done
);

  localparam int CntW = $clog2(WordLen + 1);
  localparam logic [CntW-1:0] LastBit = CntW'(WordLen - 1);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_TX,
    LOAD,
    SHIFT,
    WORDEND,
    HOLD
  } state_e;

  state_e          state_q;
  logic            dir_q, cpol_q;
  logic [DivW-1:0] div_cfg_q, div_q;
  logic [7:0]      words_left_q;
  logic [CntW-1:0] bit_cnt_q;
  logic            sclk_q, cs_n_q, en_piso_q, load_piso_q;
  logic            edge_flg_q, word_flg_q, rx_valid_q, tristate_q, busy_q, done_q;

  logic div_wrap_d, trailing_d;
  assign div_wrap_d = (div_q == div_cfg_q);
  assign trailing_d = (sclk_q != cpol_q);

  // NOTE: one clocked process owns every register, so all assignments are
  // non-blocking; the async reset branch also clears counters and config.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      dir_q        <= 1'b0;
      cpol_q       <= 1'b0;
      div_cfg_q    <= '0;
      div_q        <= '0;
      words_left_q <= '0;
      bit_cnt_q    <= '0;
      sclk_q       <= 1'b0;
      cs_n_q       <= 1'b1;
      en_piso_q    <= 1'b0;
      load_piso_q  <= 1'b0;
      edge_flg_q   <= 1'b0;
      word_flg_q   <= 1'b0;
      rx_valid_q   <= 1'b0;
      tristate_q   <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      load_piso_q <= 1'b0;
      edge_flg_q  <= 1'b0;
      rx_valid_q  <= 1'b0;
      done_q      <= 1'b0;
      unique case (state_q)
        IDLE: begin
          cs_n_q    <= 1'b1;
          en_piso_q <= 1'b0;
          sclk_q    <= cpol_q;
          busy_q    <= 1'b0;
          // busy_q is still set during the Done cycle, which blocks a restart there
          if (Start && !busy_q) begin
            dir_q        <= Dir;
            cpol_q       <= CPOL;
            div_cfg_q    <= ClkDiv;
            words_left_q <= NumWords;
            tristate_q   <= Dir;
            busy_q       <= 1'b1;
            sclk_q       <= CPOL;
            if (Dir && !TxValid) begin
              state_q <= WAIT_TX;
            end else begin
              state_q     <= LOAD;
              cs_n_q      <= 1'b0;
              en_piso_q   <= 1'b1;
              load_piso_q <= Dir;
            end
          end
        end
        WAIT_TX: begin
          if (TxValid) begin
            state_q     <= LOAD;
            cs_n_q      <= 1'b0;
            en_piso_q   <= 1'b1;
            load_piso_q <= dir_q;
          end
        end
        LOAD: begin
          state_q   <= SHIFT;
          bit_cnt_q <= '0;
          div_q     <= '0;
        end
        SHIFT: begin
          if (div_wrap_d) begin
            div_q  <= '0;
            sclk_q <= ~sclk_q;
            if (trailing_d) begin
              edge_flg_q <= 1'b1;
              bit_cnt_q  <= bit_cnt_q + CntW'(1);
              if (bit_cnt_q == LastBit) begin
                state_q    <= WORDEND;
                word_flg_q <= 1'b1;
                rx_valid_q <= ~dir_q;
              end
            end
          end else begin
            div_q <= div_q + DivW'(1);
          end
        end
        WORDEND: begin
          if (words_left_q == 8'd0) begin
            // The WORDEND cycle is the first of the ClkDiv+1 chip-select hold cycles.
            state_q    <= HOLD;
            word_flg_q <= 1'b0;
            en_piso_q  <= 1'b0;
            div_q      <= '0;
            cs_n_q     <= (div_cfg_q == '0);
          end else if (!dir_q || TxValid) begin
            state_q      <= LOAD;
            words_left_q <= words_left_q - 8'd1;
            word_flg_q   <= 1'b0;
            load_piso_q  <= dir_q;
          end
        end
        HOLD: begin
          if (cs_n_q) begin
            state_q <= IDLE;
            done_q  <= 1'b1;
          end else if (div_q == div_cfg_q - DivW'(1)) begin
            cs_n_q <= 1'b1;
          end else begin
            div_q <= div_q + DivW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign TxReady      = load_piso_q;
  assign LoadPISO     = load_piso_q;
  assign RxValid      = rx_valid_q;
  assign SCLK         = sclk_q;
  assign CS_n         = cs_n_q;
  assign EnPISO       = en_piso_q;
  assign SCLKEdgeFlg  = edge_flg_q;
  assign WordFlg      = word_flg_q;
  assign TristateMode = tristate_q;
  assign Busy         = busy_q;
  assign Done         = done_q;

endmodule

// File: tb/tb_spi_xfer_ctrl.sv
// Self-checking bench for spi_xfer_ctrl: a cycle-stamped scoreboard of expected
// LoadPISO / SCLKEdgeFlg / RxValid / Done pulses plus per-scenario level checks.
module tb_spi_xfer_ctrl;

  localparam int WL = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       Start = 1'b0, Dir = 1'b0, CPOL = 1'b0, TxValid = 1'b0;
  logic [7:0] ClkDiv = 8'd0, NumWords = 8'd0;
  logic       TxReady, RxValid, SCLK, CS_n, EnPISO, LoadPISO;
  logic       SCLKEdgeFlg, WordFlg, TristateMode, Busy, Done;

  int cyc = 0;
  int checks = 0;
  int errors = 0;
  // Expected pulse cycles per kind: 0 load, 1 edge, 2 rxvalid, 3 done
  int exp_q [4][$];

  spi_xfer_ctrl #(.WordLen(WL), .DivW(8)) dut (
    .clk(clk), .rst(rst), .Start(Start), .Dir(Dir), .CPOL(CPOL),
    .ClkDiv(ClkDiv), .NumWords(NumWords), .TxValid(TxValid),
    .TxReady(TxReady), .RxValid(RxValid), .SCLK(SCLK), .CS_n(CS_n),
    .EnPISO(EnPISO), .LoadPISO(LoadPISO), .SCLKEdgeFlg(SCLKEdgeFlg),
    .WordFlg(WordFlg), .TristateMode(TristateMode), .Busy(Busy), .Done(Done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic string kname(input int k);
    case (k)
      0: return "load";
      1: return "edge";
      2: return "rxvalid";
      default: return "done";
    endcase
  endfunction

  // Scoreboard: every observed pulse must match the oldest expected cycle of its kind.
  always @(negedge clk) begin
    logic [3:0] ev;
    int e;
    ev = {Done, RxValid, SCLKEdgeFlg, LoadPISO};
    if (!rst) begin
      for (int k = 0; k < 4; k++) begin
        if (ev[k]) begin
          checks++;
          if (exp_q[k].size() == 0) begin
            errors++;
            $display("FAIL %s: unexpected pulse at cycle %0d, none expected", kname(k), cyc);
          end else begin
            e = exp_q[k].pop_front();
            if (e != cyc) begin
              errors++;
              $display("FAIL %s: pulse at cycle %0d, expected cycle %0d", kname(k), cyc, e);
            end
            if (k == 0 && TxReady !== 1'b1) begin
              errors++;
              $display("FAIL txready: got %b with LoadPISO high, expected 1", TxReady);
            end
          end
        end
      end
    end
  end

  // Reference model of one word: returns the WORDEND cycle for a LOAD at ld.
  task automatic push_word(input int ld, input int h, input bit tx, output int w);
    if (tx) exp_q[0].push_back(ld);
    for (int b = 0; b < WL; b++) exp_q[1].push_back(ld + 1 + 2 * h * (b + 1));
    w = ld + 1 + 2 * h * WL;
    if (!tx) exp_q[2].push_back(w);
  endtask

  task automatic drive_start(input bit d, input bit cp, input int div, input int nw,
                             output int c0);
    @(negedge clk);
    Dir = d; CPOL = cp; ClkDiv = 8'(div); NumWords = 8'(nw); Start = 1'b1;
    c0 = cyc;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({CS_n, SCLK, TristateMode, Busy, Done, EnPISO, LoadPISO, TxReady,
         SCLKEdgeFlg, WordFlg, RxValid} !== 11'b100_0000_0000) begin
      errors++;
      $display("FAIL reset outputs: got %b, expected 10000000000",
               {CS_n, SCLK, TristateMode, Busy, Done, EnPISO, LoadPISO, TxReady,
                SCLKEdgeFlg, WordFlg, RxValid});
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({CS_n, Busy} !== 2'b10) begin
      errors++;
      $display("FAIL idle after reset: CS_n,Busy got %b, expected 10", {CS_n, Busy});
    end
  endtask

  task automatic test_single_tx();
    int c0, ld, w, low_cnt, sclk_bad;
    bit exp_sclk;
    TxValid = 1'b1;
    drive_start(1'b1, 1'b0, 1, 0, c0);
    ld = c0 + 1;
    push_word(ld, 2, 1'b1, w);
    exp_q[3].push_back(w + 3);
    @(negedge clk); Start = 1'b0;
    checks++;
    if ({LoadPISO, TxReady, EnPISO, CS_n, Busy, TristateMode} !== 6'b111011) begin
      errors++;
      $display("FAIL single_tx load cycle: got %b, expected 111011",
               {LoadPISO, TxReady, EnPISO, CS_n, Busy, TristateMode});
    end
    low_cnt = 0; sclk_bad = 0;
    for (int c = ld; c <= w + 4; c++) begin
      wait_until(c);
      if (CS_n === 1'b0) low_cnt++;
      exp_sclk = (c > ld && c < w) ? (((c - ld - 1) / 2) % 2 == 1) : 1'b0;
      if (SCLK !== exp_sclk) sclk_bad++;
      if (c == w) begin
        checks++;
        if (WordFlg !== 1'b1) begin
          errors++; $display("FAIL single_tx wordflg: got %b, expected 1", WordFlg);
        end
      end
      if (c == w + 3) begin
        checks++;
        if (Busy !== 1'b1) begin
          errors++; $display("FAIL single_tx busy at done: got %b, expected 1", Busy);
        end
      end
      if (c == w + 4) begin
        checks++;
        if (Busy !== 1'b0) begin
          errors++; $display("FAIL single_tx busy after done: got %b, expected 0", Busy);
        end
      end
    end
    checks++;
    if (low_cnt != 35) begin
      errors++; $display("FAIL single_tx cs_n low cycles: got %0d, expected 35", low_cnt);
    end
    checks++;
    if (sclk_bad != 0) begin
      errors++; $display("FAIL single_tx sclk waveform: %0d bad cycles, expected 0", sclk_bad);
    end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (exp_q[k].size() != 0) begin
        errors++;
        $display("FAIL single_tx %s: %0d pulses missing, expected 0", kname(k), exp_q[k].size());
        exp_q[k].delete();
      end
    end
  endtask

  task automatic test_rx_burst();
    int c0, ld, w0, w1, w2, dn, tri_bad, cs_bad, sclk_bad;
    TxValid = 1'b0;
    drive_start(1'b0, 1'b1, 0, 2, c0);
    ld = c0 + 1;
    push_word(ld, 1, 1'b0, w0);
    push_word(w0 + 1, 1, 1'b0, w1);
    push_word(w1 + 1, 1, 1'b0, w2);
    dn = w2 + 2;
    exp_q[3].push_back(dn);
    @(negedge clk); Start = 1'b0;
    tri_bad = 0; cs_bad = 0; sclk_bad = 0;
    for (int c = ld; c <= dn + 1; c++) begin
      wait_until(c);
      if (TristateMode !== 1'b0) tri_bad++;
      if (c <= w2 && CS_n !== 1'b0) cs_bad++;
      if ((c == ld || c == w0 || c == w0 + 1 || c == w1 || c == w2 || c == dn) && SCLK !== 1'b1)
        sclk_bad++;
    end
    checks++;
    if (tri_bad != 0) begin
      errors++; $display("FAIL rx_burst tristate: %0d cycles high, expected 0", tri_bad);
    end
    checks++;
    if (cs_bad != 0) begin
      errors++; $display("FAIL rx_burst cs_n continuity: %0d high cycles, expected 0", cs_bad);
    end
    checks++;
    if (sclk_bad != 0) begin
      errors++; $display("FAIL rx_burst sclk idle high: %0d low cycles, expected 0", sclk_bad);
    end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (exp_q[k].size() != 0) begin
        errors++;
        $display("FAIL rx_burst %s: %0d pulses missing, expected 0", kname(k), exp_q[k].size());
        exp_q[k].delete();
      end
    end
  endtask

  task automatic test_tx_stall();
    int c0, ld, w0, ld2, w1, stall_bad;
    TxValid = 1'b1;
    drive_start(1'b1, 1'b0, 1, 1, c0);
    ld = c0 + 1;
    push_word(ld, 2, 1'b1, w0);
    ld2 = w0 + 10;
    push_word(ld2, 2, 1'b1, w1);
    exp_q[3].push_back(w1 + 3);
    @(negedge clk); Start = 1'b0;
    TxValid = 1'b0;
    wait_until(w0);
    stall_bad = 0;
    for (int c = w0 + 1; c <= w0 + 9; c++) begin
      wait_until(c);
      if (SCLK !== 1'b0 || CS_n !== 1'b0 || SCLKEdgeFlg !== 1'b0 ||
          WordFlg !== 1'b1 || LoadPISO !== 1'b0) stall_bad++;
    end
    TxValid = 1'b1;
    checks++;
    if (stall_bad != 0) begin
      errors++; $display("FAIL tx_stall wordend hold: %0d bad cycles, expected 0", stall_bad);
    end
    wait_until(ld2);
    checks++;
    if ({LoadPISO, CS_n, WordFlg} !== 3'b100) begin
      errors++;
      $display("FAIL tx_stall second load: LoadPISO,CS_n,WordFlg got %b, expected 100",
               {LoadPISO, CS_n, WordFlg});
    end
    TxValid = 1'b0;
    wait_until(w1 + 4);
    checks++;
    if ({Busy, CS_n} !== 2'b01) begin
      errors++; $display("FAIL tx_stall end: Busy,CS_n got %b, expected 01", {Busy, CS_n});
    end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (exp_q[k].size() != 0) begin
        errors++;
        $display("FAIL tx_stall %s: %0d pulses missing, expected 0", kname(k), exp_q[k].size());
        exp_q[k].delete();
      end
    end
  endtask

  task automatic test_async_reset();
    int c0, ld, w;
    TxValid = 1'b1;
    drive_start(1'b1, 1'b0, 1, 0, c0);
    ld = c0 + 1;
    push_word(ld, 2, 1'b1, w);
    exp_q[3].push_back(w + 3);
    @(negedge clk); Start = 1'b0;
    wait_until(ld + 13);
    #1 rst = 1'b1;
    #1;
    checks++;
    if ({CS_n, SCLK, Busy, EnPISO} !== 4'b1000) begin
      errors++;
      $display("FAIL async_reset immediate: CS_n,SCLK,Busy,EnPISO got %b, expected 1000",
               {CS_n, SCLK, Busy, EnPISO});
    end
    for (int k = 0; k < 4; k++) exp_q[k].delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    drive_start(1'b1, 1'b0, 1, 0, c0);
    ld = c0 + 1;
    push_word(ld, 2, 1'b1, w);
    exp_q[3].push_back(w + 3);
    @(negedge clk); Start = 1'b0;
    wait_until(w + 4);
    checks++;
    if ({Busy, CS_n} !== 2'b01) begin
      errors++; $display("FAIL async_reset rerun end: Busy,CS_n got %b, expected 01", {Busy, CS_n});
    end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (exp_q[k].size() != 0) begin
        errors++;
        $display("FAIL async_reset %s: %0d pulses missing, expected 0", kname(k), exp_q[k].size());
        exp_q[k].delete();
      end
    end
  endtask

  task automatic test_ignored_inputs();
    int c0, ld, w0, w1, dn;
    TxValid = 1'b0;
    drive_start(1'b1, 1'b1, 2, 1, c0);
    ld = c0 + 4;
    push_word(ld, 3, 1'b1, w0);
    push_word(w0 + 1, 3, 1'b1, w1);
    dn = w1 + 4;
    exp_q[3].push_back(dn);
    @(negedge clk); Start = 1'b0;
    checks++;
    if ({CS_n, Busy, LoadPISO, SCLK} !== 4'b1101) begin
      errors++;
      $display("FAIL ignored wait_tx: CS_n,Busy,LoadPISO,SCLK got %b, expected 1101",
               {CS_n, Busy, LoadPISO, SCLK});
    end
    ClkDiv = 8'd0; NumWords = 8'd5; Dir = 1'b0; CPOL = 1'b0;
    wait_until(c0 + 3);
    TxValid = 1'b1;
    for (int c = ld; c <= dn + 3; c++) begin
      wait_until(c);
      Start = (c == ld + 5 || c == w0 || c == w1 + 2 || c == dn);
    end
    Start = 1'b0;
    TxValid = 1'b0;
    checks++;
    if ({Busy, CS_n, SCLK, TristateMode} !== 4'b0111) begin
      errors++;
      $display("FAIL ignored end: Busy,CS_n,SCLK,TristateMode got %b, expected 0111",
               {Busy, CS_n, SCLK, TristateMode});
    end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (exp_q[k].size() != 0) begin
        errors++;
        $display("FAIL ignored %s: %0d pulses missing, expected 0", kname(k), exp_q[k].size());
        exp_q[k].delete();
      end
    end
  endtask

  task automatic test_max_div();
    int c0, ld, w;
    logic [7:0] got;
    TxValid = 1'b1;
    drive_start(1'b1, 1'b0, 255, 0, c0);
    ld = c0 + 1;
    push_word(ld, 256, 1'b1, w);
    exp_q[3].push_back(w + 257);
    @(negedge clk); Start = 1'b0;
    wait_until(ld + 256); got[0] = SCLK;
    wait_until(ld + 257); got[1] = SCLK;
    wait_until(ld + 512); got[2] = SCLK;
    wait_until(ld + 513); got[3] = SCLK;
    checks++;
    if (got[3:0] !== 4'b0110) begin
      errors++; $display("FAIL max_div sclk half-period: samples got %b, expected 0110", got[3:0]);
    end
    wait_until(w - 1); got[4] = WordFlg;
    wait_until(w);     got[5] = WordFlg;
    wait_until(w + 255); got[6] = CS_n;
    wait_until(w + 256); got[7] = CS_n;
    checks++;
    if (got[7:4] !== 4'b1010) begin
      errors++;
      $display("FAIL max_div word/hold: CS_n,CS_n,WordFlg,WordFlg got %b, expected 1010", got[7:4]);
    end
    wait_until(w + 258);
    checks++;
    if (Busy !== 1'b0) begin
      errors++; $display("FAIL max_div busy after done: got %b, expected 0", Busy);
    end
    TxValid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (exp_q[k].size() != 0) begin
        errors++;
        $display("FAIL max_div %s: %0d pulses missing, expected 0", kname(k), exp_q[k].size());
        exp_q[k].delete();
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_tx();
    test_rx_burst();
    test_tx_stall();
    test_async_reset();
    test_ignored_inputs();
    test_max_div();
    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "time limit");
  end

endmodule
